traffic_phase_scheduler: RTL and testbench



---
 rtl/traffic_pkg.sv | 22 ++
 rtl/traffic_phase_scheduler_release_pacer.sv | 27 ++
 rtl/traffic_phase_scheduler.sv | 148 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light and phase types shared by the traffic phase scheduler
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_TO_EW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_TO_NS = 3'd5,
    WALK      = 3'd6
  } phase_t;

  localparam int WALK_TICKS = 10;

endpackage

// File: rtl/traffic_phase_scheduler_release_pacer.sv
// rtl/traffic_phase_scheduler_release_pacer.sv - paces one-car-per-interval decrement pulses for one approach
module release_pacer (
  input  logic       traffic_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       car_in_queue,
  input  logic [3:0] interval,
  output logic       dec_car
);

  logic [3:0] r_release_cnt;

  // Dropping enable clears the count, so each green starts a fresh interval.
  always_ff @(posedge traffic_clk) begin
    if (reset || !enable) begin
      r_release_cnt <= 4'd0;
      dec_car       <= 1'b0;
    end else if (r_release_cnt == interval - 4'd1) begin
      r_release_cnt <= 4'd0;
      dec_car       <= car_in_queue;
    end else begin
      r_release_cnt <= r_release_cnt + 4'd1;
      dec_car       <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-approach light phase sequencer with queue release pulses
// Optional pedestrian walk phase enabled by macro PED_WALK_EN.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN     = 8,
  parameter int MAX_GREEN     = 32,
  parameter int YELLOW_TICKS  = 4,
  parameter int ALL_RED_TICKS = 2,
  parameter int RELEASE_TICKS = 2,
  parameter int LONG_QUEUE    = 8
) (
  input  logic       traffic_clk,
  input  logic       reset,
  input  logic       ns_car_in_queue,
  input  logic [3:0] ns_queue_count,
  input  logic       ew_car_in_queue,
  input  logic [3:0] ew_queue_count,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       ns_dec_car,
  output logic       ew_dec_car,
  output logic [2:0] phase
`ifdef PED_WALK_EN
  ,
  input  logic       ped_req,
  output logic       walk
`endif
);

  localparam logic [7:0] MIN_LAST    = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST    = 8'(MAX_GREEN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] RED_LAST    = 8'(ALL_RED_TICKS - 1);
  localparam logic [3:0] LONG_Q      = 4'(LONG_QUEUE);
  localparam logic [3:0] REL_IVL     = 4'(RELEASE_TICKS);
`ifdef PED_WALK_EN
  localparam logic [7:0] WALK_LAST   = 8'(WALK_TICKS - 1);
`endif

  phase_t     r_state;
  logic [7:0] r_phase_timer;
  logic       w_ns_exit;
  logic       w_ew_exit;
`ifdef PED_WALK_EN
  logic       r_ped_pending;
  logic       r_walk_to_ew;
`endif

  // A green yields only to a waiting opposing queue, and never before MIN_GREEN.
  assign w_ns_exit = (r_state == NS_GREEN) && (r_phase_timer >= MIN_LAST) && ew_car_in_queue &&
                     (!ns_car_in_queue || (ew_queue_count >= LONG_Q) || (r_phase_timer >= MAX_LAST));
  assign w_ew_exit = (r_state == EW_GREEN) && (r_phase_timer >= MIN_LAST) && ns_car_in_queue &&
                     (!ew_car_in_queue || (ns_queue_count >= LONG_Q) || (r_phase_timer >= MAX_LAST));

  always_ff @(posedge traffic_clk) begin
    if (reset) begin
      r_state       <= NS_GREEN;
      r_phase_timer <= 8'd0;
`ifdef PED_WALK_EN
      r_ped_pending <= 1'b0;
      r_walk_to_ew  <= 1'b0;
`endif
    end else begin
      r_phase_timer <= (r_phase_timer == 8'hFF) ? r_phase_timer : r_phase_timer + 8'd1;
`ifdef PED_WALK_EN
      if (ped_req) r_ped_pending <= 1'b1;
`endif
      case (r_state)
        NS_GREEN: if (w_ns_exit) begin
          r_state <= NS_YELLOW; r_phase_timer <= 8'd0;
        end
        NS_YELLOW: if (r_phase_timer == YELLOW_LAST) begin
          r_state <= RED_TO_EW; r_phase_timer <= 8'd0;
        end
        RED_TO_EW: if (r_phase_timer == RED_LAST) begin
          r_phase_timer <= 8'd0;
`ifdef PED_WALK_EN
          if (r_ped_pending) begin
            r_state <= WALK; r_walk_to_ew <= 1'b1; r_ped_pending <= 1'b0;
          end else
`endif
          r_state <= EW_GREEN;
        end
        EW_GREEN: if (w_ew_exit) begin
          r_state <= EW_YELLOW; r_phase_timer <= 8'd0;
        end
        EW_YELLOW: if (r_phase_timer == YELLOW_LAST) begin
          r_state <= RED_TO_NS; r_phase_timer <= 8'd0;
        end
        RED_TO_NS: if (r_phase_timer == RED_LAST) begin
          r_phase_timer <= 8'd0;
`ifdef PED_WALK_EN
          if (r_ped_pending) begin
            r_state <= WALK; r_walk_to_ew <= 1'b0; r_ped_pending <= 1'b0;
          end else
`endif
          r_state <= NS_GREEN;
        end
`ifdef PED_WALK_EN
        WALK: if (r_phase_timer == WALK_LAST) begin
          r_state <= r_walk_to_ew ? EW_GREEN : NS_GREEN; r_phase_timer <= 8'd0;
        end
`endif
        default: begin
          r_state <= NS_GREEN; r_phase_timer <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    ns_light = RED;
    ew_light = RED;
    case (r_state)
      NS_GREEN:  ns_light = GREEN;
      NS_YELLOW: ns_light = YELLOW;
      EW_GREEN:  ew_light = GREEN;
      EW_YELLOW: ew_light = YELLOW;
      default: ;
    endcase
  end

  assign phase = r_state;
`ifdef PED_WALK_EN
  assign walk = (r_state == WALK);
`endif

  // Pacing stops on the exit-decision cycle so no pulse lands in yellow.
  release_pacer u_ns_pacer (
    .traffic_clk  (traffic_clk),
    .reset        (reset),
    .enable       ((r_state == NS_GREEN) && !w_ns_exit),
    .car_in_queue (ns_car_in_queue),
    .interval     (REL_IVL),
    .dec_car      (ns_dec_car)
  );

  release_pacer u_ew_pacer (
    .traffic_clk  (traffic_clk),
    .reset        (reset),
    .enable       ((r_state == EW_GREEN) && !w_ew_exit),
    .car_in_queue (ew_car_in_queue),
    .interval     (REL_IVL),
    .dec_car      (ew_dec_car)
  );

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scoreboard bench for traffic_phase_scheduler
`timescale 1ns/1ps
module tb_traffic_phase_scheduler;

  logic       traffic_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ns_car_in_queue = 1'b0;
  logic [3:0] ns_queue_count = 4'd0;
  logic       ew_car_in_queue = 1'b0;
  logic [3:0] ew_queue_count = 4'd0;
  logic [1:0] ns_light, ew_light;
  logic       ns_dec_car, ew_dec_car;
  logic [2:0] phase;
`ifdef PED_WALK_EN
  logic       ped_req = 1'b0;
  logic       walk;
`endif

  always #5 traffic_clk = ~traffic_clk;

  traffic_phase_scheduler dut (
    .traffic_clk     (traffic_clk),
    .reset           (reset),
    .ns_car_in_queue (ns_car_in_queue),
    .ns_queue_count  (ns_queue_count),
    .ew_car_in_queue (ew_car_in_queue),
    .ew_queue_count  (ew_queue_count),
    .ns_light        (ns_light),
    .ew_light        (ew_light),
    .ns_dec_car      (ns_dec_car),
    .ew_dec_car      (ew_dec_car),
    .phase           (phase)
`ifdef PED_WALK_EN
    ,
    .ped_req         (ped_req),
    .walk            (walk)
`endif
  );

  typedef struct { int cyc; logic [2:0] ph; } ph_ev_t;
  typedef struct { int cyc; logic ns; } dec_ev_t;

  ph_ev_t     exp_ph_q[$];
  dec_ev_t    exp_dec_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [2:0] exp_cur = 3'd0;
  int         ns_cnt = 0, ew_cnt = 0;
  bit         hold_ns = 0, hold_ew = 0;
  bit         pend_ns = 0, pend_ew = 0;

  function automatic logic [1:0] ns_light_of(logic [2:0] p);
    return (p == 3'd0) ? 2'd2 : (p == 3'd1) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] ew_light_of(logic [2:0] p);
    return (p == 3'd3) ? 2'd2 : (p == 3'd4) ? 2'd1 : 2'd0;
  endfunction

  task automatic push_ph(input int c, input logic [2:0] p);
    exp_ph_q.push_back('{cyc: c, ph: p});
  endtask

  task automatic push_dec(input int c, input logic ns);
    exp_dec_q.push_back('{cyc: c, ns: ns});
  endtask

  task automatic drive_queues;
    ns_queue_count  = 4'(ns_cnt);
    ns_car_in_queue = (ns_cnt != 0);
    ew_queue_count  = 4'(ew_cnt);
    ew_car_in_queue = (ew_cnt != 0);
  endtask

  // Queue counters react to last cycle's pulse; the expected phase/pulse for this cycle come from the scoreboard.
  task automatic check_cycle;
    logic e_ns, e_ew;
    if (pend_ns && !hold_ns && ns_cnt > 0) ns_cnt--;
    if (pend_ew && !hold_ew && ew_cnt > 0) ew_cnt--;
    drive_queues();
    if (exp_ph_q.size() > 0 && exp_ph_q[0].cyc == cyc) begin
      exp_cur = exp_ph_q[0].ph;
      void'(exp_ph_q.pop_front());
    end
    e_ns = 1'b0;
    e_ew = 1'b0;
    if (exp_dec_q.size() > 0 && exp_dec_q[0].cyc == cyc) begin
      if (exp_dec_q[0].ns) e_ns = 1'b1; else e_ew = 1'b1;
      void'(exp_dec_q.pop_front());
    end
    checks++;
    if (phase !== exp_cur) begin
      failures++; $display("FAIL phase cyc=%0d actual=%0d required=%0d", cyc, phase, exp_cur);
    end
    checks++;
    if (ns_light !== ns_light_of(exp_cur)) begin
      failures++; $display("FAIL ns_light cyc=%0d actual=%0d required=%0d", cyc, ns_light, ns_light_of(exp_cur));
    end
    checks++;
    if (ew_light !== ew_light_of(exp_cur)) begin
      failures++; $display("FAIL ew_light cyc=%0d actual=%0d required=%0d", cyc, ew_light, ew_light_of(exp_cur));
    end
    checks++;
    if (ns_dec_car !== e_ns) begin
      failures++; $display("FAIL ns_dec_car cyc=%0d actual=%0b required=%0b", cyc, ns_dec_car, e_ns);
    end
    checks++;
    if (ew_dec_car !== e_ew) begin
      failures++; $display("FAIL ew_dec_car cyc=%0d actual=%0b required=%0b", cyc, ew_dec_car, e_ew);
    end
`ifdef PED_WALK_EN
    checks++;
    if (walk !== (exp_cur == 3'd6)) begin
      failures++; $display("FAIL walk cyc=%0d actual=%0b required=%0b", cyc, walk, exp_cur == 3'd6);
    end
`endif
    pend_ns = (ns_dec_car === 1'b1);
    pend_ew = (ew_dec_car === 1'b1);
  endtask

  task automatic step;
    @(negedge traffic_clk);
    cyc++;
    check_cycle();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_ph_q.delete();
    exp_dec_q.delete();
    drive_queues();
    repeat (n) @(negedge traffic_clk);
    pend_ns = 0;
    pend_ew = 0;
    checks++;
    if (phase !== 3'd0 || ns_light !== 2'd2 || ew_light !== 2'd0 || ns_dec_car !== 1'b0 || ew_dec_car !== 1'b0) begin
      failures++;
      $display("FAIL reset_values actual phase=%0d ns=%0d ew=%0d dec=%0b%0b required phase=0 ns=2 ew=0 dec=00",
               phase, ns_light, ew_light, ns_dec_car, ew_dec_car);
    end
    reset   = 1'b0;
    cyc     = 0;
    exp_cur = 3'd0;
    check_cycle();
  endtask

  task automatic finish_check(input string name);
    checks++;
    if (exp_ph_q.size() != 0 || exp_dec_q.size() != 0) begin
      failures++;
      $display("FAIL %s_events actual pending phase=%0d dec=%0d required 0/0", name, exp_ph_q.size(), exp_dec_q.size());
    end
  endtask

  task automatic test_reset;
    ns_cnt = 0; ew_cnt = 0; hold_ns = 0; hold_ew = 0;
    do_reset(2);
    run_to(50);
    finish_check("reset");
  endtask

  task automatic test_ew_drain;
    ns_cnt = 0; ew_cnt = 3; hold_ns = 0; hold_ew = 0;
    do_reset(2);
    push_ph(8, 3'd1); push_ph(12, 3'd2); push_ph(14, 3'd3);
    push_dec(16, 0); push_dec(18, 0); push_dec(20, 0);
    run_to(30);
    finish_check("ew_drain");
    checks++;
    if (ew_cnt != 0) begin
      failures++; $display("FAIL ew_drained actual=%0d required=0", ew_cnt);
    end
  endtask

  task automatic test_max_green;
    ns_cnt = 15; ew_cnt = 2; hold_ns = 1; hold_ew = 0;
    do_reset(2);
    for (int c = 2; c <= 30; c += 2) push_dec(c, 1);
    push_dec(40, 0); push_dec(42, 0);
    push_ph(32, 3'd1); push_ph(36, 3'd2); push_ph(38, 3'd3);
    push_ph(46, 3'd4); push_ph(50, 3'd5); push_ph(52, 3'd0);
    run_to(53);
    finish_check("max_green");
  endtask

  task automatic test_long_queue;
    ns_cnt = 5; ew_cnt = 1; hold_ns = 0; hold_ew = 0;
    do_reset(2);
    push_dec(2, 1); push_dec(4, 1); push_dec(6, 1);
    push_ph(8, 3'd1); push_ph(12, 3'd2); push_ph(14, 3'd3);
    run_to(3);
    ew_cnt = 8;
    drive_queues();
    run_to(15);
    finish_check("long_queue");
    checks++;
    if (ns_cnt != 2) begin
      failures++; $display("FAIL long_queue_ns_left actual=%0d required=2", ns_cnt);
    end
  endtask

  task automatic test_reset_mid_phase;
    ns_cnt = 15; ew_cnt = 15; hold_ns = 1; hold_ew = 1;
    do_reset(2);
    push_dec(2, 1); push_dec(4, 1); push_dec(6, 1);
    push_ph(8, 3'd1); push_ph(12, 3'd2); push_ph(14, 3'd3);
    push_dec(16, 0); push_dec(18, 0); push_dec(20, 0);
    push_ph(22, 3'd4);
    run_to(23);
    finish_check("pre_mid_reset");
    do_reset(1);
    push_dec(2, 1); push_dec(4, 1); push_dec(6, 1);
    push_ph(8, 3'd1);
    run_to(9);
    finish_check("mid_reset");
  endtask

`ifdef PED_WALK_EN
  task automatic test_walk;
    ns_cnt = 0; ew_cnt = 3; hold_ns = 0; hold_ew = 0;
    do_reset(2);
    push_ph(8, 3'd1); push_ph(12, 3'd2); push_ph(14, 3'd6); push_ph(24, 3'd3);
    push_dec(26, 0); push_dec(28, 0); push_dec(30, 0);
    run_to(2);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run_to(31);
    finish_check("walk");
  endtask
`endif

  initial begin
    test_reset();
    test_ew_drain();
    test_max_green();
    test_long_queue();
    test_reset_mid_phase();
`ifdef PED_WALK_EN
    test_walk();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
